// File: rtl/riscv_trap_ctrl.sv
// riscv_trap_ctrl
// Trap sequencer: latches rising-edge interrupt requests, masks them with mie,
// arbitrates them against synchronous exceptions, stalls the pipeline until it
// drains, then emits a single trap strobe with the cause and redirects the PC.
// It also tracks the handler-active state until mret.

module riscv_trap_ctrl #(
    parameter int IRQ_NUM = 16,
    parameter int MXLEN   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IRQ_NUM-1:0] irq_i,
    input  logic [MXLEN-1:0]   mie_i,
    input  logic               exc_valid_i,
    input  logic [3:0]         exc_code_i,
    input  logic               mret_i,
    input  logic               drain_done_i,
    output logic               stall_o,
    output logic               trap_o,
    output logic               pc_sel_o,
    output logic [MXLEN-1:0]   mcause_o,
    output logic               in_trap_o
);

    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_TRAP    = 2'd2,
        ST_HANDLER = 2'd3
    } state_t;

    // Interrupt cause: interrupt flag in the MSB, code 16+k in the low bits.
    function automatic logic [MXLEN-1:0] irq_cause(input logic [IDX_W-1:0] idx);
        logic [MXLEN-1:0] c;
        c            = '0;
        c[MXLEN-1]   = 1'b1;
        c[5:0]       = 6'd16 + {2'b00, idx};
        return c;
    endfunction

    // Exception cause: MSB clear, raw exception code in the low bits.
    function automatic logic [MXLEN-1:0] exc_cause(input logic [3:0] code);
        logic [MXLEN-1:0] c;
        c      = '0;
        c[3:0] = code;
        return c;
    endfunction

    state_t             r_state;
    logic [IRQ_NUM-1:0] r_irq_prev;
    logic [IRQ_NUM-1:0] r_pend;
    logic [MXLEN-1:0]   r_cause;
    logic               r_cap_irq;
    logic [IDX_W-1:0]   r_cap_idx;
    logic               r_stall;
    logic               r_trap;
    logic               r_pc_sel;
    logic               r_in_trap;

    state_t             w_state_nxt;
    logic [MXLEN-1:0]   w_cause_nxt;
    logic               w_cap_irq_nxt;
    logic [IDX_W-1:0]   w_cap_idx_nxt;
    logic [IRQ_NUM-1:0] w_rise;
    logic [IRQ_NUM-1:0] w_elig;
    logic [IRQ_NUM-1:0] w_clr;
    logic [IRQ_NUM-1:0] w_pend_nxt;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_unused_mie;

    assign w_rise       = irq_i & ~r_irq_prev;
    assign w_elig       = r_pend & mie_i[16 +: IRQ_NUM];
    // Only mie bits 16.. carry interrupt enables for the platform lines.
    assign w_unused_mie = ^(mie_i & ~(MXLEN'({IRQ_NUM{1'b1}}) << 16));

    // Fixed-priority select: lowest eligible line index wins.
    always_comb begin
        w_sel_idx = {IDX_W{1'b0}};
        for (int k = IRQ_NUM - 1; k >= 0; k--) begin
            w_sel_idx = w_elig[k] ? IDX_W'(k) : w_sel_idx;
        end
    end

    // Pending update: the TRAP cycle clears the captured line, a new edge re-sets it.
    always_comb begin
        w_clr = '0;
        for (int k = 0; k < IRQ_NUM; k++) begin
            w_clr[k] = (r_state == ST_TRAP) && r_cap_irq && (r_cap_idx == IDX_W'(k));
        end
        w_pend_nxt = (r_pend & ~w_clr) | w_rise;
    end

    // Next-state and cause-capture logic of the trap sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_cause_nxt   = r_cause;
        w_cap_irq_nxt = r_cap_irq;
        w_cap_idx_nxt = r_cap_idx;
        case (r_state)
            ST_IDLE: begin
                if (exc_valid_i) begin
                    w_state_nxt   = ST_DRAIN;
                    w_cause_nxt   = exc_cause(exc_code_i);
                    w_cap_irq_nxt = 1'b0;
                    w_cap_idx_nxt = {IDX_W{1'b0}};
                end else if (|w_elig) begin
                    w_state_nxt   = ST_DRAIN;
                    w_cause_nxt   = irq_cause(w_sel_idx);
                    w_cap_irq_nxt = 1'b1;
                    w_cap_idx_nxt = w_sel_idx;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // A late exception displaces a captured interrupt; that line stays pending.
                if (exc_valid_i && r_cap_irq) begin
                    w_cause_nxt   = exc_cause(exc_code_i);
                    w_cap_irq_nxt = 1'b0;
                    w_cap_idx_nxt = {IDX_W{1'b0}};
                end else begin
                    w_cause_nxt   = r_cause;
                end
                if (drain_done_i) begin
                    w_state_nxt = ST_TRAP;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_TRAP: begin
                w_state_nxt = ST_HANDLER;
            end
            ST_HANDLER: begin
                // A nested exception outranks a simultaneous mret.
                if (exc_valid_i) begin
                    w_state_nxt   = ST_DRAIN;
                    w_cause_nxt   = exc_cause(exc_code_i);
                    w_cap_irq_nxt = 1'b0;
                    w_cap_idx_nxt = {IDX_W{1'b0}};
                end else if (mret_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HANDLER;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Edge-detect history and pending interrupt latches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq_prev <= '0;
            r_pend     <= '0;
        end else begin
            r_irq_prev <= irq_i;
            r_pend     <= w_pend_nxt;
        end
    end

    // FSM state, captured cause and registered outputs derived from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_cause   <= '0;
            r_cap_irq <= 1'b0;
            r_cap_idx <= {IDX_W{1'b0}};
            r_stall   <= 1'b0;
            r_trap    <= 1'b0;
            r_pc_sel  <= 1'b0;
            r_in_trap <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cause   <= w_cause_nxt;
            r_cap_irq <= w_cap_irq_nxt;
            r_cap_idx <= w_cap_idx_nxt;
            r_stall   <= (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_TRAP);
            r_trap    <= (w_state_nxt == ST_TRAP);
            r_pc_sel  <= (w_state_nxt == ST_TRAP);
            // Handler flag persists through a nested trap and drops only on return to IDLE.
            r_in_trap <= (w_state_nxt == ST_HANDLER) ||
                         (r_in_trap && (w_state_nxt != ST_IDLE));
        end
    end

    assign stall_o   = r_stall;
    assign trap_o    = r_trap;
    assign pc_sel_o  = r_pc_sel;
    assign mcause_o  = r_cause;
    assign in_trap_o = r_in_trap;

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Testbench for riscv_trap_ctrl: directed stimulus pushes expected trap causes
// into a queue; a negedge monitor pops and compares on every trap strobe.

module tb_riscv_trap_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] irq;
    logic [31:0] mie;
    logic        exc_v;
    logic [3:0]  exc_code;
    logic        mret;
    logic        drain;
    logic        stall_o;
    logic        trap_o;
    logic        pc_sel_o;
    logic [31:0] mcause_o;
    logic        in_trap_o;

    typedef struct {
        logic [31:0] cause;
        logic        in_trap;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    riscv_trap_ctrl #(.IRQ_NUM(16), .MXLEN(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .irq_i        (irq),
        .mie_i        (mie),
        .exc_valid_i  (exc_v),
        .exc_code_i   (exc_code),
        .mret_i       (mret),
        .drain_done_i (drain),
        .stall_o      (stall_o),
        .trap_o       (trap_o),
        .pc_sel_o     (pc_sel_o),
        .mcause_o     (mcause_o),
        .in_trap_o    (in_trap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_trap(input logic [31:0] cause, input logic in_trap);
        exp_t e;
        e.cause   = cause;
        e.in_trap = in_trap;
        q.push_back(e);
    endtask

    task automatic do_mret();
        mret = 1'b1;
        step();
        mret = 1'b0;
    endtask

    // Bounded wait until the handler is entered (in_trap set, stall dropped).
    task automatic wait_handler(input string nm);
        int n;
        n = 0;
        while (!(in_trap_o && !stall_o) && n < 20) begin
            step();
            n++;
        end
        chk(nm, {31'd0, (in_trap_o && !stall_o)}, 32'd1);
    endtask

    // Scoreboard monitor: every trap strobe must match the oldest expected cause.
    always @(negedge clk) begin
        if (!rst && trap_o) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_trap: got mcause 0x%08h expected no trap", mcause_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("trap_mcause", mcause_o, e.cause);
                chk("trap_pc_sel", {31'd0, pc_sel_o}, 32'd1);
                chk("trap_stall", {31'd0, stall_o}, 32'd1);
                chk("trap_in_trap", {31'd0, in_trap_o}, {31'd0, e.in_trap});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; irq = 16'h0000; mie = 32'h0000_0000; exc_v = 1'b0;
        exc_code = 4'h0; mret = 1'b0; drain = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_trap", {31'd0, trap_o}, 32'd0);
        chk("rst_pc_sel", {31'd0, pc_sel_o}, 32'd0);
        chk("rst_mcause", mcause_o, 32'h0000_0000);
        chk("rst_in_trap", {31'd0, in_trap_o}, 32'd0);

        // Basic interrupt on line 0
        mie = 32'h0001_0000; drain = 1'b1;
        expect_trap(32'h8000_0010, 1'b0);
        irq = 16'h0001;
        step(); chk("t1_no_stall_yet", {31'd0, stall_o}, 32'd0);
        step(); chk("t1_stall", {31'd0, stall_o}, 32'd1);
        chk("t1_mcause", mcause_o, 32'h8000_0010);
        step(); chk("t1_trap_strobe", {31'd0, trap_o}, 32'd1);
        step(); chk("t1_trap_single", {31'd0, trap_o}, 32'd0);
        chk("t1_in_trap", {31'd0, in_trap_o}, 32'd1);
        chk("t1_stall_off", {31'd0, stall_o}, 32'd0);
        irq = 16'h0000;
        do_mret();
        chk("t1_mret_idle", {31'd0, in_trap_o}, 32'd0);
        step(); step();
        chk("t1_pend_cleared", {31'd0, stall_o}, 32'd0);

        // Masking and priority: 3 and 5 together, only 5 enabled
        mie = 32'h0020_0000;
        expect_trap(32'h8000_0015, 1'b0);
        irq = 16'h0028;
        step(); step();
        chk("t2_masked_pick", mcause_o, 32'h8000_0015);
        wait_handler("t2_h1");
        mie = 32'h0028_0000;
        expect_trap(32'h8000_0013, 1'b0);
        do_mret();
        chk("t2_idle_after_mret", {31'd0, stall_o}, 32'd0);
        step();
        chk("t2_reenter_drain", {31'd0, stall_o}, 32'd1);
        chk("t2_line3_cause", mcause_o, 32'h8000_0013);
        wait_handler("t2_h2");
        irq = 16'h0000;
        do_mret();
        step();

        // Exception overrides a captured interrupt in DRAIN
        mie = 32'h0004_0000; drain = 1'b0;
        irq = 16'h0004;
        step(); step();
        chk("t3_irq_captured", mcause_o, 32'h8000_0012);
        step();
        chk("t3_hold_drain", {31'd0, stall_o}, 32'd1);
        chk("t3_no_trap_yet", {31'd0, trap_o}, 32'd0);
        exc_v = 1'b1; exc_code = 4'h2;
        expect_trap(32'h0000_0002, 1'b0);
        step();
        exc_v = 1'b0;
        chk("t3_exc_override", mcause_o, 32'h0000_0002);
        drain = 1'b1;
        wait_handler("t3_h1");
        expect_trap(32'h8000_0012, 1'b0);
        do_mret();
        step();
        chk("t3_irq_retaken", {31'd0, stall_o}, 32'd1);
        wait_handler("t3_h2");
        irq = 16'h0000;
        do_mret();
        step();

        // Nested exception colliding with mret
        exc_v = 1'b1; exc_code = 4'h5;
        expect_trap(32'h0000_0005, 1'b0);
        step();
        exc_v = 1'b0;
        chk("t4_exc_drain", {31'd0, stall_o}, 32'd1);
        chk("t4_exc_cause", mcause_o, 32'h0000_0005);
        wait_handler("t4_h1");
        exc_v = 1'b1; exc_code = 4'hB; mret = 1'b1;
        expect_trap(32'h0000_000B, 1'b1);
        step();
        exc_v = 1'b0; mret = 1'b0;
        chk("t4_nested_drain", {31'd0, stall_o}, 32'd1);
        chk("t4_nested_in_trap", {31'd0, in_trap_o}, 32'd1);
        chk("t4_nested_cause", mcause_o, 32'h0000_000B);
        wait_handler("t4_h2");
        do_mret();
        chk("t4_return", {31'd0, in_trap_o}, 32'd0);

        // Level hold, re-edge, and an edge during the TRAP cycle
        mie = 32'h0002_0000;
        expect_trap(32'h8000_0011, 1'b0);
        irq = 16'h0002;
        step(); step();
        wait_handler("t5_h1");
        do_mret();
        repeat (3) step();
        chk("t5_level_no_retrap", {31'd0, stall_o}, 32'd0);
        irq = 16'h0000;
        step();
        irq = 16'h0002;
        expect_trap(32'h8000_0011, 1'b0);
        step(); step();
        chk("t5_reedge_drain", {31'd0, stall_o}, 32'd1);
        wait_handler("t5_h2");
        irq = 16'h0000;
        do_mret();
        irq = 16'h0002;
        expect_trap(32'h8000_0011, 1'b0);
        step(); step();
        chk("t5_third_drain", {31'd0, stall_o}, 32'd1);
        irq = 16'h0000;
        step();
        chk("t5_third_trap", {31'd0, trap_o}, 32'd1);
        irq = 16'h0002;
        step();
        chk("t5_third_handler", {31'd0, in_trap_o}, 32'd1);
        expect_trap(32'h8000_0011, 1'b0);
        do_mret();
        step();
        chk("t5_trap_cycle_edge_kept", {31'd0, stall_o}, 32'd1);
        wait_handler("t5_h4");
        irq = 16'h0000;
        do_mret();
        step();

        // Asynchronous reset in the middle of DRAIN
        drain = 1'b0;
        exc_v = 1'b1; exc_code = 4'h7;
        step();
        exc_v = 1'b0;
        chk("t6_in_drain", {31'd0, stall_o}, 32'd1);
        chk("t6_cause", mcause_o, 32'h0000_0007);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_stall", {31'd0, stall_o}, 32'd0);
        chk("t6_async_trap", {31'd0, trap_o}, 32'd0);
        chk("t6_async_pc_sel", {31'd0, pc_sel_o}, 32'd0);
        chk("t6_async_mcause", mcause_o, 32'h0000_0000);
        chk("t6_async_in_trap", {31'd0, in_trap_o}, 32'd0);
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        drain = 1'b1;
        repeat (4) step();
        chk("t6_idle_after_rst", {31'd0, stall_o}, 32'd0);
        chk("t6_mcause_after_rst", mcause_o, 32'h0000_0000);

        chk("queue_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/riscv_trap_ctrl.md
# riscv_trap_ctrl

Trap sequencer for the RISC-V core. It latches external interrupt requests, masks them with the CSR `mie` value, and arbitrates them against synchronous exceptions. It halts fetch and waits for the pipeline to drain, then fires the one-cycle `trap` strobe and `mcause` value into the CSR file and redirects the PC to `mtvec`. It sits between the interrupt sources / pipeline hazard logic and the CSR block, and owns the global interrupt-enable state across `mret`.

## Interface
- `IRQ_NUM`, 16: number of platform interrupt lines. Legal range 1..16; line k maps to `mie` bit 16+k and cause code 16+k.
- `MXLEN`, 32: register width. Must match the CSR block.
- `clk_i` in 1: core clock, single clock domain.
- `rst_i` in 1: reset, asynchronous, active-high.
- `irq_i` in IRQ_NUM: interrupt lines, synchronous to `clk_i`, rising-edge triggered.
- `mie_i` in MXLEN: current `mie` CSR value.
- `exc_valid_i` in 1: synchronous exception from the pipeline, single-cycle pulse.
- `exc_code_i` in 4: exception cause code, valid with `exc_valid_i`.
- `mret_i` in 1: `mret` retired, single-cycle pulse.
- `drain_done_i` in 1: pipeline empty and `pc` stable, level.
- `stall_o` out 1: halt fetch/issue.
- `trap_o` out 1: one-cycle strobe to the CSR trap input; saves `pc`/`mcause`.
- `pc_sel_o` out 1: next PC = `mtvec`, coincident with `trap_o`.
- `mcause_o` out MXLEN: cause value to the CSR file.
- `in_trap_o` out 1: handler active; interrupts globally disabled.

## Operation
- **Edge detect:** `irq_prev` holds the registered copy of `irq_i`. `pend[k]` is set when `irq_i[k] & ~irq_prev[k]`. `pend[k]` is cleared in the TRAP cycle only if k is the captured line. If a set and a clear hit the same bit in the same cycle, the set wins. Pending bits are independent of the mask.
- **Eligible:** `elig = pend & mie_i[16 +: IRQ_NUM]`. Arbitration is fixed priority, lowest index first.
- **Cause encoding:**
  - Interrupt: `mcause = {1'b1, zeros, 16+k}`.
  - Exception: `mcause = {1'b0, zeros, exc_code_i}`.
- **FSM states:** IDLE, DRAIN, TRAP, HANDLER.
  - IDLE: if `exc_valid_i`, capture the exception cause and go to DRAIN. Else if `elig != 0`, capture the lowest line index and its cause and go to DRAIN. `mret_i` is ignored.
  - DRAIN: `stall_o`=1. If `exc_valid_i` arrives while an interrupt is captured, the exception cause replaces it; the interrupt line stays pending and uncleared. When `drain_done_i`=1, go to TRAP.
  - TRAP, exactly 1 cycle: `trap_o`=1, `pc_sel_o`=1, `stall_o`=1. Clear the captured pend bit if the cause is an interrupt. Go to HANDLER.
  - HANDLER: `in_trap_o`=1 and interrupts are blocked.
    - `exc_valid_i` captures the exception cause and goes to DRAIN (nested exception; `in_trap_o` stays 1 through the resulting trap).
    - Otherwise `mret_i` returns to IDLE.
    - If both arrive in the same cycle, the exception wins.
- `mcause_o` holds the last captured cause from DRAIN entry until the next capture.
- `stall_o` = (state is DRAIN or TRAP).
- Reset mid-operation: all state returns to reset values immediately. A trap in progress is abandoned; no `trap_o` is emitted.

## Timing
- **Reset values:** `stall_o`=0, `trap_o`=0, `pc_sel_o`=0, `in_trap_o`=0, `mcause_o`=0; `pend`, `irq_prev` and the captured cause are 0; state is IDLE.
- **Interrupt latency:** line rises, sampled at edge t → pend set after t → DRAIN after t+1, with `stall_o` high from t+1.
- **Exception latency:** `exc_valid_i` at edge t in IDLE → DRAIN after t.
- **Drain to trap:** `drain_done_i` high at edge d in DRAIN → TRAP cycle between d and d+1 → HANDLER after d+1.
  - Minimum interrupt-to-trap: 2 cycles from the edge, if `drain_done_i` is already high.
- **Return:** `mret_i` at edge m → IDLE after m. A still-eligible interrupt re-enters DRAIN after m+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Basic interrupt:** `mie_i`=0x0001_0000, pulse `irq_i[0]`, `drain_done_i`=1 → `stall_o` 1 cycle after pend, single `trap_o`/`pc_sel_o` pulse, `mcause_o`=0x8000_0010, pend[0] cleared, `in_trap_o`=1.
- **Masking and priority:** raise `irq_i[3]` and `irq_i[5]` together with `mie_i`=0x0020_0000 → line 5 taken (`mcause_o`=0x8000_0015), pend[3] stays 1. Later set `mie_i` bit 19 and `mret_i` → line 3 taken next (0x8000_0013).
- **Exception override in DRAIN:** interrupt captured, `drain_done_i`=0, then `exc_valid_i` with code 2 → `mcause_o`=0x0000_0002 at trap, interrupt pend bit still 1, taken after `mret_i`.
- **Nested exception / mret collision:** in HANDLER, `exc_valid_i` (code 11) and `mret_i` in the same cycle → DRAIN, `mcause_o`=0x0000_000B, `in_trap_o` stays 1.
- **Level hold and re-edge:** hold `irq_i[1]` high across trap and `mret_i` → no second trap. Drop and re-raise → second trap. A rising edge in the TRAP cycle for the captured line leaves pend[1] set.
- **Async reset:** assert `rst_i` mid-DRAIN, between clock edges → all outputs 0 immediately, no `trap_o` after release, state IDLE.
